instruction_fetch: RTL and testbench

//   IF-stage fetch unit: owns the fetch PC, issues single-outstanding requests to instruction memory,
//   and buffers returned words in a small prefetch queue. Its outputs are the inst/pc pair consumed by the
//   IF/ID pipeline register, and it generates IStall toward that register and the hazard unit.

---
 rtl/instruction_fetch_pkg.sv | 31 +++
 rtl/fetch_buffer.sv | 85 ++++++++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the IF-stage fetch unit and its prefetch queue.
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INST      = 32'd0;

  // Queue occupancy counter; wide enough for the largest legal depth (4).
  localparam int unsigned CNT_W = 3;
  typedef logic [CNT_W-1:0] count_t;

  // Fetch FSM: IDLE = nothing outstanding, REQ = request on the bus,
  // WAIT = accepted and awaiting data, DRAIN = accepted but made stale by a redirect.
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_WAIT  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

  // One prefetch queue entry.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, inst} entries between the instruction memory and IF/ID.
// Supports simultaneous push and pop, a single-cycle flush, and pointers that
// wrap modulo DEPTH (DEPTH need not be a power of two).
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output count_t       count_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;

  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t LAST = ptr_t'(DEPTH - 1);

  fetch_entry_t mem_q [SLOTS];
  ptr_t         rd_ptr_q, rd_ptr_d;
  ptr_t         wr_ptr_q, wr_ptr_d;
  count_t       count_q, count_d;
  logic         push_ok, pop_ok;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST) ? '0 : p + ptr_t'(1);
  endfunction

  // Never pop an empty queue; a push into a full queue is only legal alongside a pop.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q < count_t'(DEPTH)) || pop_ok);

  // Next pointer/count values; flush wins over push and pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + count_t'(1);
        2'b01:   count_d = count_q - count_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q gates every read, so stale contents are never visible.
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// IF-stage fetch unit: owns the fetch PC, runs a single-outstanding request
// handshake to instruction memory, and presents the prefetch queue head to IF/ID.
// BUF_DEPTH must lie in 1..4.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_ID_Write,
  input  logic        DStall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        IStall
);

  if_state_e    state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;     // address of the request memory accepted

  fetch_entry_t head;
  fetch_entry_t push_entry;
  count_t       count;
  count_t       count_after;
  logic         empty;
  logic         push, pop, accept;
  logic         room_now, room_after;

  // Queue traffic this cycle; a redirect suppresses both push and pop.
  always_comb begin
    accept      = (state_q == IF_REQ) && imem_ack;
    pop         = !empty && IF_ID_Write && !DStall && !redirect_valid;
    push        = (state_q == IF_WAIT) && imem_rvalid && !redirect_valid;
    push_entry  = '{pc: req_pc_q, inst: imem_rdata};
    count_after = count + count_t'(push) - count_t'(pop);
    room_now    = count < count_t'(BUF_DEPTH);
    room_after  = count_after < count_t'(BUF_DEPTH);
  end

  // Fetch PC and accepted-address bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (accept) req_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = align_word(redirect_pc);
    else if (accept)     fetch_pc_d = fetch_pc_q + 32'd4;   // wraps naturally at 2^32
  end

  // Next-state logic for the request handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_IDLE: begin
        if (redirect_valid || room_now) state_d = IF_REQ;
      end
      IF_REQ: begin
        // Without ack a redirected request is simply re-issued at the new address.
        if (imem_ack) state_d = redirect_valid ? IF_DRAIN : IF_WAIT;
      end
      IF_WAIT: begin
        if (redirect_valid)   state_d = imem_rvalid ? IF_REQ : IF_DRAIN;
        else if (imem_rvalid) state_d = room_after ? IF_REQ : IF_IDLE;
      end
      IF_DRAIN: begin
        // The stale response is dropped; a flush always leaves room.
        if (imem_rvalid) state_d = (redirect_valid || room_after) ? IF_REQ : IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // State, PC and accepted-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IF_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty)
  );

  assign imem_req  = (state_q == IF_REQ);
  assign imem_addr = fetch_pc_q;
  assign IStall    = empty;
  assign inst_out  = empty ? BUBBLE_INST : head.inst;
  assign pc_out    = empty ? 32'd0 : head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming with a 1-cycle memory,
// back-pressure, redirects at each handshake phase, PC wrap and mid-flight reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IF_ID_Write;
  logic        DStall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        IStall;

  // Memory stand-in: automatic 1-cycle responder or hand-driven handshake.
  logic        auto_mem;
  logic        man_ack, man_rvalid;
  logic [31:0] man_rdata;
  logic        pend_q;
  logic [31:0] pend_addr_q;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] addr);
    return addr ^ 32'hA5A5_5A5A;
  endfunction

  assign imem_ack    = auto_mem ? imem_req : man_ack;
  assign imem_rvalid = auto_mem ? pend_q : man_rvalid;
  assign imem_rdata  = auto_mem ? mw(pend_addr_q) : man_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
    end else begin
      pend_q      <= imem_req && imem_ack;
      pend_addr_q <= imem_addr;
    end
  end

  // {imem_req, IStall, imem_addr, pc_out, inst_out}
  wire [97:0] obs = {imem_req, IStall, imem_addr, pc_out, inst_out};

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_Write    (IF_ID_Write),
    .DStall         (DStall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .IStall         (IStall)
  );

  // Reset values, then the first five cycles of fetch against the 1-cycle memory.
  task automatic test_reset;
    logic [97:0] tab [5];
    tab[0] = {1'b1, 1'b1, 32'h0, 32'h0, 32'h0};
    tab[1] = {1'b0, 1'b1, 32'h4, 32'h0, 32'h0};
    tab[2] = {1'b1, 1'b0, 32'h4, 32'h0, mw(32'h0)};
    tab[3] = {1'b0, 1'b1, 32'h8, 32'h0, 32'h0};
    tab[4] = {1'b1, 1'b0, 32'h8, 32'h4, mw(32'h4)};
    rst_n = 1'b0; auto_mem = 1'b1; man_ack = 1'b0; man_rvalid = 1'b0; man_rdata = 32'd0;
    IF_ID_Write = 1'b1; DStall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== {1'b0, 1'b1, 32'h0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_values: obs=%h exp=%h", obs, {1'b0, 1'b1, 32'h0, 32'h0, 32'h0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs !== tab[i]) begin
        n_fail++; $display("FAIL first_fetch[%0d]: obs=%h exp=%h", i, obs, tab[i]);
      end
      @(negedge clk);
    end
    exp_pc = 32'h8;   // heads 0 and 4 were consumed
  endtask

  // Free-running consumption; every presented head must be the next sequential PC.
  task automatic test_stream(input int n, input int exp_pops);
    int pops = 0;
    for (int i = 0; i < n; i++) begin
      IF_ID_Write = 1'b1; DStall = 1'b0;
      if (!IStall) begin
        n_checks++;
        if ({pc_out, inst_out} !== {exp_pc, mw(exp_pc)}) begin
          n_fail++; $display("FAIL stream_head: pc=%h inst=%h exp pc=%h inst=%h", pc_out, inst_out, exp_pc, mw(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      @(negedge clk);
    end
    if (exp_pops >= 0) begin
      n_checks++;
      if (pops != exp_pops) begin
        n_fail++; $display("FAIL stream_rate: pops=%0d exp=%0d", pops, exp_pops);
      end
    end
  endtask

  // Back-pressure via IF_ID_Write (hold=1) or DStall (hold=0): queue fills, requests stop, head stable.
  task automatic test_hold(input bit use_ifid);
    for (int i = 0; i < 6; i++) begin
      IF_ID_Write = use_ifid ? 1'b0 : 1'b1;
      DStall      = use_ifid ? 1'b0 : 1'b1;
      if (!IStall) begin
        n_checks++;
        if ({pc_out, inst_out} !== {exp_pc, mw(exp_pc)}) begin
          n_fail++; $display("FAIL hold_head(ifid=%0d): pc=%h inst=%h exp pc=%h", use_ifid, pc_out, inst_out, exp_pc);
        end
      end
      if (i >= 4) begin
        n_checks++;
        if ({imem_req, IStall} !== 2'b00) begin
          n_fail++; $display("FAIL hold_full(ifid=%0d): req=%b istall=%b exp req=0 istall=0", use_ifid, imem_req, IStall);
        end
      end
      @(negedge clk);
    end
  endtask

  // Redirect while WAIT (with queue occupied) then a stale response in DRAIN.
  task automatic test_redirect_wait;
    logic [97:0] e;
    rst_n = 1'b0; auto_mem = 1'b0; man_ack = 1'b0; man_rvalid = 1'b0;
    IF_ID_Write = 1'b0; DStall = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = {1'b1, 1'b1, 32'h0, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rw_req0: obs=%h exp=%h", obs, e); end
    man_ack = 1'b1;
    @(negedge clk);
    e = {1'b0, 1'b1, 32'h4, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rw_wait0: obs=%h exp=%h", obs, e); end
    man_ack = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hAAAA_0001;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h4, 32'h0, 32'hAAAA_0001}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rw_push0: obs=%h exp=%h", obs, e); end
    man_rvalid = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    e = {1'b0, 1'b1, 32'h100, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rw_flush: obs=%h exp=%h", obs, e); end
    redirect_valid = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    e = {1'b1, 1'b1, 32'h100, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rw_stale_drop: obs=%h exp=%h", obs, e); end
    man_rvalid = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    e = {1'b0, 1'b1, 32'h104, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rw_wait100: obs=%h exp=%h", obs, e); end
    man_ack = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBBBB_0100;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h104, 32'h100, 32'hBBBB_0100}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rw_first_after: obs=%h exp=%h", obs, e); end
  endtask

  // Redirect coinciding with ack (-> DRAIN), with rvalid in WAIT, and with an un-acked REQ.
  task automatic test_redirect_ack;
    logic [97:0] e;
    man_rvalid = 1'b0; man_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    e = {1'b0, 1'b1, 32'h200, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ra_drain: obs=%h exp=%h", obs, e); end
    man_ack = 1'b0; redirect_valid = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_0104;
    @(negedge clk);
    e = {1'b1, 1'b1, 32'h200, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ra_drain_drop: obs=%h exp=%h", obs, e); end
    man_rvalid = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    e = {1'b0, 1'b1, 32'h204, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ra_wait200: obs=%h exp=%h", obs, e); end
    man_ack = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_0200;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    e = {1'b1, 1'b1, 32'h300, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ra_rvalid_drop: obs=%h exp=%h", obs, e); end
    man_rvalid = 1'b0; redirect_pc = 32'h0000_0402;
    @(negedge clk);
    e = {1'b1, 1'b1, 32'h400, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ra_req_abandon: obs=%h exp=%h", obs, e); end
    redirect_valid = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    e = {1'b0, 1'b1, 32'h404, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ra_wait400: obs=%h exp=%h", obs, e); end
    man_ack = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hCCCC_0400;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h404, 32'h400, 32'hCCCC_0400}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ra_push400: obs=%h exp=%h", obs, e); end
  endtask

  // fetch_pc wrap from 0xFFFF_FFFC, then asynchronous reset while WAIT.
  task automatic test_wrap_and_reset;
    logic [97:0] e;
    man_rvalid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    e = {1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL wrap_req: obs=%h exp=%h", obs, e); end
    redirect_valid = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    e = {1'b0, 1'b1, 32'h0, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL wrap_addr: obs=%h exp=%h", obs, e); end
    man_ack = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDDDD_FFFC;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hDDDD_FFFC}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL wrap_push: obs=%h exp=%h", obs, e); end
    man_rvalid = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    e = {1'b0, 1'b0, 32'h4, 32'hFFFF_FFFC, 32'hDDDD_FFFC}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL wrap_wait: obs=%h exp=%h", obs, e); end
    man_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    e = {1'b0, 1'b1, 32'h0, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL async_reset: obs=%h exp=%h", obs, e); end
    @(negedge clk);
    rst_n = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    e = {1'b1, 1'b1, 32'h0, 32'h0, 32'h0}; n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_discard: obs=%h exp=%h", obs, e); end
    man_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream(20, 10);
    test_hold(1'b1);
    test_stream(12, -1);
    test_hold(1'b0);
    test_stream(12, -1);
    test_redirect_wait();
    test_redirect_ack();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
